// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_pkg                                                   |
// | Purpose  : Shared opcode encodings, flag bit positions and the FSM   |
// |            state type for the ALU arbiter.                           |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package alu_pkg;

    // Opcode encodings. Everything above OP_LAST is illegal.
    localparam logic [5:0] OP_AND  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_ANDI = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_LAST = 6'd4;

    // Bit positions inside the 4-bit {V, N, Z, C} flag vector.
    localparam int unsigned FLG_C = 0;
    localparam int unsigned FLG_Z = 1;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_V = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arb2                                                   |
// | Purpose  : Two-way round-robin grant. A lone request always wins;    |
// |            on contention ptr picks the winner.                       |
// | Ports    : req[1:0] in  - request vector                             |
// |            ptr      in  - preferred requester under contention       |
// |            en       in  - grants allowed this cycle                  |
// |            gnt[1:0] out - one-hot grant (zero when en is low)        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_arbiter                                               |
// | Purpose  : Shares one combinational ALU between two requesters with  |
// |            round-robin arbitration; returns result/flags on a shared |
// |            response channel tagged with the requester id.            |
// | Ports    : clk, rst_n (async active-low)                             |
// |            reqN_valid/ready/a/b/op - requester handshakes (N = 0, 1) |
// |            alu_a/alu_b/alu_opcode  - registered operands to the ALU  |
// |            alu_result + flags      - ALU outputs                     |
// |            rsp_valid/ready/id/result/flags/err - response channel    |
// |            busy                    - FSM not in IDLE                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic             busy
);

    // Flags reported for a rejected opcode: only Z set, matching result 0.
    localparam logic [3:0] c_err_flags = 4'(1 << FLG_Z);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rr_ptr;
    logic             r_id;
    logic             r_illegal;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [OPW-1:0]   r_alu_op;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic [3:0]       r_rsp_flags;
    logic             r_rsp_err;

    logic [1:0]       w_gnt;
    logic             w_grant;
    logic             w_arb_en;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [OPW-1:0]   w_sel_op;
    logic             w_rsp_hs;

    // Gating with rst_n keeps both readies low while reset is held,
    // even though the state register already reads IDLE.
    assign w_arb_en = (r_state == IDLE) && rst_n;

    rr_arb2 u_rr_arb2 (
        .req ({req1_valid, req0_valid}),
        .ptr (r_rr_ptr),
        .en  (w_arb_en),
        .gnt (w_gnt)
    );

    assign w_grant  = |w_gnt;
    assign w_sel_a  = w_gnt[1] ? req1_a  : req0_a;
    assign w_sel_b  = w_gnt[1] ? req1_b  : req0_b;
    assign w_sel_op = w_gnt[1] ? req1_op : req0_op;
    assign w_rsp_hs = (r_state == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= 1'b0;
            r_id         <= 1'b0;
            r_illegal    <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_alu_a   <= w_sel_a;
                r_alu_b   <= w_sel_b;
                r_alu_op  <= w_sel_op;
                r_id      <= w_gnt[1];
                r_illegal <= (w_sel_op > OPW'(OP_LAST));
            end
            // The ALU is combinational on the registered operands, so its
            // outputs are settled during EXEC.
            if (r_state == EXEC) begin
                r_rsp_id <= r_id;
                if (r_illegal) begin
                    r_rsp_result <= '0;
                    r_rsp_flags  <= c_err_flags;
                    r_rsp_err    <= 1'b1;
                end else begin
                    r_rsp_result <= alu_result;
                    r_rsp_flags  <= {alu_overflow, alu_negative, alu_zero, alu_carry};
                    r_rsp_err    <= 1'b0;
                end
            end
            // Favour whoever was not just served.
            if (w_rsp_hs) begin
                r_rr_ptr <= ~r_rsp_id;
            end
        end
    end

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_op;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_alu_arbiter                                            |
// | Purpose  : Directed self-checking bench for alu_arbiter with a small |
// |            behavioural ALU attached to the ALU-side ports.           |
// | Ports    : none                                                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [5:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [5:0]  alu_opcode;
    logic        alu_carry, alu_zero, alu_negative, alu_overflow;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.WIDTH(32), .OPW(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_op      (req0_op),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_op      (req1_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU. SUB carry means borrow. Illegal opcodes drive a
    // deliberately odd result and all flags so an override is visible.
    logic [32:0] w_sum;
    always_comb begin
        w_sum        = '0;
        alu_result   = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        alu_zero     = 1'b0;
        alu_negative = 1'b0;
        case (alu_opcode)
            OP_AND, OP_ANDI: alu_result = alu_a & alu_b;
            OP_ADD, OP_ADDI: begin
                w_sum        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = w_sum[31:0];
                alu_carry    = w_sum[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (w_sum[31] != alu_a[31]);
            end
            OP_SUB: begin
                alu_result   = alu_a - alu_b;
                alu_carry    = (alu_a < alu_b);
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            default: begin
                alu_result   = 32'hDEAD_BEEF;
                alu_carry    = 1'b1;
                alu_overflow = 1'b1;
            end
        endcase
        alu_zero     = (alu_result == 32'd0) || (alu_opcode > OP_LAST);
        alu_negative = alu_result[31] || (alu_opcode > OP_LAST);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op);
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        @(negedge clk);
        check("ready", {62'd0, req1_ready, req0_ready}, id ? 64'd2 : 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("alu_a", 64'(alu_a), 64'(a));
        check("alu_op", 64'(alu_opcode), 64'(op));
    endtask

    task automatic check_fields(input bit id, input logic [31:0] res, input logic [3:0] flg,
                                input bit err);
        check("rsp_id", 64'(rsp_id), 64'(id));
        check("rsp_result", 64'(rsp_result), 64'(res));
        check("rsp_flags", 64'(rsp_flags), 64'(flg));
        check("rsp_err", 64'(rsp_err), 64'(err));
    endtask

    // Called right after issue(): EXEC cycle shows no response, next cycle does.
    task automatic expect_rsp(input bit id, input logic [31:0] res, input logic [3:0] flg,
                              input bit err);
        @(negedge clk);
        check("rsp_valid_exec", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("rsp_valid_resp", 64'(rsp_valid), 64'd1);
        check_fields(id, res, flg, err);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;

        // Reset state, with a valid present to prove ready is held low.
        #12;
        check("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result}, 64'd0);
        check("rst_alu", {alu_opcode, alu_a}, 64'd0);
        req0_valid = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;

        // Single ADD 5+7 from requester 0.
        issue(1'b0, 32'd5, 32'd7, OP_ADD);
        expect_rsp(1'b0, 32'd12, 4'b0000, 1'b0);
        @(negedge clk);
        check("idle_after_hs", {62'd0, busy, rsp_valid}, 64'd0);

        // Backpressure: requester 0 AND with rsp_ready low; requester 1 waits.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h0000_F0F0; req0_b = 32'h0000_FF00; req0_op = OP_AND;
        @(negedge clk);
        check("bp_ready0", {62'd0, req1_ready, req0_ready}, 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_op = OP_ADD;
        @(negedge clk);
        check("bp_exec_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result},
                  {1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_F000});
            check("bp_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_cycle_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        @(negedge clk);
        check("bp_accept_next", {62'd0, req1_ready, req0_ready}, 64'd2);
        @(posedge clk); #1; req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check_fields(1'b1, 32'd30, 4'b0000, 1'b0);

        // Contention: both held; last served was 1 so order is 0,1,0,1.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_op = OP_SUB;
        req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_op = OP_ADD;
        for (int k = 0; k < 4; k++) begin
            bit found;
            bit exp_id;
            found  = 1'b0;
            exp_id = k[0];
            for (int w = 0; w < 6 && !found; w++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) found = 1'b1;
            end
            check("cont_grant", {62'd0, req1_ready, req0_ready}, exp_id ? 64'd2 : 64'd1);
            @(negedge clk);
            @(negedge clk);
            check("cont_rsp_valid", 64'(rsp_valid), 64'd1);
            if (exp_id) check_fields(1'b1, 32'h8000_0000, 4'b1100, 1'b0);
            else        check_fields(1'b0, 32'd0, 4'b0010, 1'b0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Illegal opcode from requester 1.
        issue(1'b1, 32'd1, 32'd1, 6'h2A);
        expect_rsp(1'b1, 32'd0, 4'b0010, 1'b1);

        // Flags pass-through: ADDI 0xFFFFFFFF + 1.
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, OP_ADDI);
        expect_rsp(1'b0, 32'd0, 4'b0011, 1'b0);

        // Reset during EXEC drops the operation.
        issue(1'b1, 32'd9, 32'd9, OP_ADD);
        rst_n = 1'b0;
        #1;
        check("rst_exec_out", {rsp_valid, rsp_id, rsp_err, busy, rsp_flags, rsp_result}, 64'd0);
        check("rst_exec_alu", {alu_opcode, alu_a}, 64'd0);
        check("rst_exec_alub", 64'(alu_b), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_rsp_after_rst", {62'd0, rsp_valid, busy}, 64'd0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_op = OP_ADD;
        req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4; req1_op = OP_ADD;
        @(negedge clk);
        check("post_rst_grant", {62'd0, req1_ready, req0_ready}, 64'd1);
        @(posedge clk); #1; req0_valid = 1'b0;
        expect_rsp(1'b0, 32'd4, 4'b0000, 1'b0);
        @(negedge clk);
        check("post_rst_grant1", {62'd0, req1_ready, req0_ready}, 64'd2);
        @(posedge clk); #1; req1_valid = 1'b0;
        expect_rsp(1'b1, 32'd8, 4'b0000, 1'b0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin controller that shares the single combinational 32-bit ALU between requester 0 (integer execute path) and requester 1 (address/immediate path). It accepts an operation on a valid/ready handshake and registers the operands into the ALU. It then captures the ALU result and flags one cycle later and returns them on a shared response channel tagged with the requester id. Illegal opcodes are rejected with an error flag and do not use the ALU result.

## Interface
- WIDTH, 32, operand/result width
- OPW, 6, opcode width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_op / req1_op  in  OPW  opcode
- alu_a, alu_b  out  WIDTH  registered operands to the ALU
- alu_opcode  out  OPW  registered opcode to the ALU
- alu_result  in  WIDTH  ALU result
- alu_carry, alu_zero, alu_negative, alu_overflow  in  1  ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that owns the response
- rsp_result  out  WIDTH  captured result
- rsp_flags  out  4  {overflow, negative, zero, carry}
- rsp_err  out  1  opcode was illegal
- busy  out  1  state is not IDLE

## Operation
- Legal opcodes are 0 AND, 1 ADD, 2 SUB, 3 ANDI and 4 ADDI. Values 5..63 are illegal.
- The FSM has three states: IDLE, EXEC and RESP.
- IDLE behaviour:
  - If no valid is asserted, the FSM stays in IDLE.
  - If exactly one valid is asserted, that requester is granted.
  - If both are asserted, the requester selected by rr_ptr is granted.
  - On grant, the granted requester's ready is driven high combinationally in that cycle.
  - Also on grant: alu_a, alu_b, alu_opcode and the id register are loaded, an illegal-opcode bit is latched, and the FSM moves to EXEC.
- EXEC behaviour:
  - rsp_result, rsp_flags, rsp_id and rsp_err are captured.
  - For an illegal opcode, the captured values are result 0, flags 4'b0010 (zero set) and rsp_err 1.
  - The FSM moves to RESP.
- RESP behaviour:
  - rsp_valid is 1 and all rsp_* outputs are held stable.
  - On rsp_valid & rsp_ready, rr_ptr is set to ~rsp_id and the FSM moves to IDLE.
- rr_ptr favours the requester that was not served last. Its reset value is 0.
- The ready outputs are 0 in every state except IDLE. A requester must hold valid and operands until it sees ready.
- alu_a, alu_b and alu_opcode keep their last value until the next grant.
- Carry, overflow, zero and negative are taken verbatim from the ALU for legal opcodes. The arbiter does not recompute them.

## Timing
- Reset (asynchronous, active-low) forces the following:
  - The FSM goes to IDLE and rr_ptr to 0.
  - All outputs are 0: alu_a, alu_b, alu_opcode, rsp_*, busy, and both ready signals.
- Latency and throughput:
  - Accept happens at cycle 0 (ready high).
  - rsp_valid rises at cycle 2.
  - The earliest next accept is the cycle after the response handshake.
  - Minimum spacing is one operation per 3 cycles.
- If rsp_ready is held high, the response lasts exactly one cycle. If rsp_ready is low, the response is held indefinitely.
- A valid that arrives while busy sees ready stay 0. It is arbitrated in the first IDLE cycle.
- Reset asserted mid-operation (EXEC or RESP) drops the operation, so no response is produced. The requester must re-issue it.
- Simultaneous valids on the first cycle after reset: requester 0 wins.
- Continuous contention: grants alternate 0, 1, 0, 1, and neither requester waits for more than one other operation.

## Structure
- The shared package alu_pkg holds:
  - the opcode constants OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI and OP_LAST = 4;
  - the flag bit indices FLG_C = 0, FLG_Z = 1, FLG_N = 2, FLG_V = 3;
  - the state enum {IDLE, EXEC, RESP}.
- A sub-module rr_arb2 (2-way round-robin grant) is natural:
  - inputs: req[1:0], ptr, en;
  - output: one-hot gnt[1:0].
- The FSM, operand registers and response registers stay in alu_arbiter.

## Test plan
- **Single ADD:** req0 issues A=5, B=7, op=1 with rsp_ready=1.
  - Expect ready0 at cycle 0.
  - Expect rsp_valid at cycle 2 with id 0, result 12, flags 0, err 0.
- **Contention:** both valids are held continuously with rsp_ready=1; req0 issues SUB 3−3 and req1 issues ADD 0x7FFFFFFF+1.
  - Expect grant order 0, 1, 0, 1.
  - Expect the SUB to give result 0, zero=1.
  - Expect the ADD to give result 0x80000000, overflow=1, negative=1.
- **Backpressure:** hold rsp_ready=0 for 5 cycles after rsp_valid.
  - Expect the response to stay stable.
  - Expect both ready signals to stay 0 and the new req1 valid to stay unaccepted.
  - Expect req1 to be accepted in the cycle after the handshake.
- **Illegal opcode:** req1 issues op=6'h2A with A=1, B=1.
  - Expect result 0, flags 4'b0010, err 1, id 1.
- **Reset in EXEC:** assert rst_n=0 in the EXEC cycle.
  - Expect all outputs 0 immediately.
  - Expect no rsp_valid after release.
  - Expect a simultaneous req0/req1 after release to grant 0 first.
- **Flags pass-through:** ADDI 0xFFFFFFFF+1.
  - Expect result 0 with carry=1 and zero=1.
